inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of instruction-word entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports pc_i  input  25  fetch address from fetcher; pc_valid_i  input  1  address offered; pc_ready_o  output  1  address accepted.
REQ-005 SHALL have ports mem_req_o  output  1  read request; mem_addr_o  output  25  request address; mem_gnt_i  input  1  request granted.
REQ-006 SHALL have ports mem_rvalid_i  input  1  read data valid; mem_rdata_i  input  32  read data (responses strictly in request order).
REQ-007 SHALL have port flush_i  input  1  redirect from branch/exception; discard all buffered and in-flight fetches.
REQ-008 SHALL have ports inst_valid_o  output  1; inst_o  output  32; inst_addr_o  output  25; inst_ready_i  input  1 (decoder handshake).
REQ-009 SHALL have ports count_o  output  4  occupied entries; err_o  output  1  sticky protocol error.

Function
REQ-010 SHALL keep credits = occupied + in-flight (granted, not yet returned, not discarded); room = credits < DEPTH.
REQ-011 SHALL drive mem_req_o = pc_valid_i & room & (state==RUN) & ~flush_i, and mem_addr_o = pc_i combinationally.
REQ-012 SHALL drive pc_ready_o = mem_req_o & mem_gnt_i; a fetch transfers only when pc_valid_i & pc_ready_o.
REQ-013 SHALL push each transferred address into an in-flight address FIFO (depth DEPTH) for pairing with its response.
REQ-014 SHALL, on mem_rvalid_i in RUN with in-flight>0, write {in-flight head addr, mem_rdata_i} to data FIFO, visible on outputs the next cycle (1-cycle latency, no bypass).
REQ-015 SHALL present data FIFO head on inst_o/inst_addr_o with inst_valid_o = occupied>0; pop when inst_valid_o & inst_ready_i.
REQ-016 SHALL allow push, pop and new grant in the same cycle; credit accounting makes overflow impossible.
REQ-017 SHALL implement FSM RUN/DRAIN: flush_i in any state empties data FIFO, sets discard = in-flight (excluding any rvalid that cycle), clears in-flight FIFO; goes DRAIN if discard>0 else RUN.
REQ-018 SHALL in DRAIN drop each mem_rvalid_i and decrement discard; at discard 0 go RUN; no requests issued in DRAIN.
REQ-019 SHALL treat flush_i as highest priority: same-cycle rvalid, pop and grant are discarded/ignored (grant cannot occur since mem_req_o=0).
REQ-020 SHALL set err_o on mem_rvalid_i when in-flight==0 in RUN (or discard==0 in DRAIN); response ignored; err_o cleared only by reset.
REQ-021 SHALL wrap FIFO pointers modulo DEPTH; count_o equals occupied entries, 0..DEPTH.

Reset
REQ-022 SHALL on rst_n low asynchronously: state RUN, FIFOs empty, discard 0, inst_valid_o 0, count_o 0, err_o 0, inst_o/inst_addr_o 0.
REQ-023 SHALL, with rst_n low, drive mem_req_o 0 and pc_ready_o 0; reset mid-operation discards all entries; responses after release with none outstanding flag err_o.

Verification
REQ-024 Basic: pc_i 0,1,2 with gnt=1, rvalid 1 cycle later with data A0,A1,A2, inst_ready_i=1 -> inst_o A0,A1,A2 with inst_addr_o 0,1,2, each 1 cycle after its rvalid.
REQ-025 Full: DEPTH=4, inst_ready_i=0, 6 addresses offered -> exactly 4 accepted, pc_ready_o 0 thereafter, count_o=4; one pop -> one more accepted.
REQ-026 Flush in flight: 3 granted, 0 returned, flush_i pulse -> count_o 0, DRAIN; next 3 rvalids dropped, no inst_valid_o; then RUN and new pc_i 0x100 fetched normally.
REQ-027 Simultaneous: rvalid and flush_i same cycle -> data dropped, discard counts remaining in-flight only; rvalid+pop+grant same cycle without flush -> count_o unchanged.
REQ-028 Error: rvalid with nothing in flight -> err_o 1 next cycle, count_o unchanged, err_o held until rst_n low.
REQ-029 Reset mid-stream: rst_n low with count_o=3 -> inst_valid_o 0, count_o 0 immediately (asynchronous), mem_req_o 0.

Source files
------------

// File: rtl/inst_queue_if.sv
// rtl/inst_queue_if.sv - fetch, memory and decoder handshakes of the instruction queue
interface inst_queue_if;
  logic [24:0] pc_i;
  logic        pc_valid_i;
  logic        pc_ready_o;
  logic        mem_req_o;
  logic [24:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        flush_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [24:0] inst_addr_o;
  logic        inst_ready_i;

  modport slave (
    input  pc_i, pc_valid_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, flush_i, inst_ready_i,
    output pc_ready_o, mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_addr_o
  );

  modport master (
    output pc_i, pc_valid_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, flush_i, inst_ready_i,
    input  pc_ready_o, mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_addr_o
  );
endinterface

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - credit-based instruction prefetch queue with flush/drain of in-flight reads
module inst_queue #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  inst_queue_if.slave  bus,
  output logic [3:0]   count_o,
  output logic         err_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_discard, w_discard_nxt;

  logic [24:0]   r_if_addr [DEPTH];
  logic [PW-1:0] r_if_wptr, r_if_rptr;
  logic [CW-1:0] r_if_cnt;

  logic [31:0]   r_dq_inst [DEPTH];
  logic [24:0]   r_dq_addr [DEPTH];
  logic [PW-1:0] r_dq_wptr, r_dq_rptr;
  logic [CW-1:0] r_dq_cnt;

  logic          r_err;

  logic [CW:0]   w_credits;
  logic          w_room, w_run, w_mem_req, w_grant, w_rsp_ok, w_pop, w_err_set, w_drop_now;
  logic [CW-1:0] w_outstanding;

  // Credits cover both buffered words and reads still owed by memory, so a grant never overflows.
  assign w_credits  = {1'b0, r_if_cnt} + {1'b0, r_dq_cnt};
  assign w_room     = w_credits < (CW+1)'(DEPTH);
  assign w_run      = (r_state == RUN);
  assign w_mem_req  = rst_n & bus.pc_valid_i & w_room & w_run & ~bus.flush_i;
  assign w_grant    = w_mem_req & bus.mem_gnt_i;
  assign w_rsp_ok   = bus.mem_rvalid_i & ~bus.flush_i & w_run & (r_if_cnt != '0);
  assign w_pop      = (r_dq_cnt != '0) & bus.inst_ready_i & ~bus.flush_i;
  assign w_err_set  = bus.mem_rvalid_i & ~bus.flush_i &
                      (w_run ? (r_if_cnt == '0) : (r_discard == '0));

  // Reads still owed by memory: tracked by the address FIFO in RUN, by the discard counter in DRAIN.
  assign w_outstanding = w_run ? r_if_cnt : r_discard;
  assign w_drop_now    = bus.mem_rvalid_i & (w_outstanding != '0);

  assign bus.mem_req_o    = w_mem_req;
  assign bus.mem_addr_o   = bus.pc_i;
  assign bus.pc_ready_o   = w_grant;
  assign bus.inst_valid_o = (r_dq_cnt != '0);
  assign bus.inst_o       = r_dq_inst[r_dq_rptr];
  assign bus.inst_addr_o  = r_dq_addr[r_dq_rptr];
  assign count_o          = 4'(r_dq_cnt);
  assign err_o            = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RUN;
      r_discard <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_discard <= w_discard_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_discard_nxt = r_discard;
    if (bus.flush_i) begin
      w_discard_nxt = w_outstanding - CW'(w_drop_now);
      w_state_nxt   = (w_discard_nxt != '0) ? DRAIN : RUN;
    end else if (r_state == DRAIN) begin
      if (bus.mem_rvalid_i && (r_discard != '0)) begin
        w_discard_nxt = r_discard - CW'(1);
      end
      if (w_discard_nxt == '0) begin
        w_state_nxt = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_wptr <= '0;
      r_if_rptr <= '0;
      r_if_cnt  <= '0;
      r_dq_wptr <= '0;
      r_dq_rptr <= '0;
      r_dq_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_if_addr[i] <= '0;
        r_dq_inst[i] <= '0;
        r_dq_addr[i] <= '0;
      end
    end else if (bus.flush_i) begin
      r_if_wptr <= '0;
      r_if_rptr <= '0;
      r_if_cnt  <= '0;
      r_dq_wptr <= '0;
      r_dq_rptr <= '0;
      r_dq_cnt  <= '0;
    end else begin
      if (w_grant) begin
        r_if_addr[r_if_wptr] <= bus.pc_i;
        r_if_wptr            <= r_if_wptr + PW'(1);
      end
      if (w_rsp_ok) begin
        r_dq_inst[r_dq_wptr] <= bus.mem_rdata_i;
        r_dq_addr[r_dq_wptr] <= r_if_addr[r_if_rptr];
        r_dq_wptr            <= r_dq_wptr + PW'(1);
        r_if_rptr            <= r_if_rptr + PW'(1);
      end
      if (w_pop) begin
        r_dq_rptr <= r_dq_rptr + PW'(1);
      end
      r_if_cnt <= r_if_cnt + CW'(w_grant) - CW'(w_rsp_ok);
      r_dq_cnt <= r_dq_cnt + CW'(w_rsp_ok) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - directed self-checking bench for inst_queue (DEPTH=4)
module tb_inst_queue;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] count_o;
  logic       err_o;
  int         checks = 0;
  int         errors = 0;

  inst_queue_if bus();

  inst_queue #(.DEPTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .count_o (count_o),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.pc_i         = '0;
    bus.pc_valid_i   = 1'b0;
    bus.mem_gnt_i    = 1'b1;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    bus.flush_i      = 1'b0;
    bus.inst_ready_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle();
    bus.pc_valid_i = 1'b1;
    #2;
    checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%0b exp=0", bus.mem_req_o); end
    checks++; if (bus.pc_ready_o !== 1'b0) begin errors++; $display("FAIL reset_pc_ready got=%0b exp=0", bus.pc_ready_o); end
    checks++; if ({bus.inst_valid_o, count_o, err_o} !== 6'b0) begin errors++; $display("FAIL reset_status got=%0b/%0d/%0b exp=0/0/0", bus.inst_valid_o, count_o, err_o); end
    checks++; if ({bus.inst_o, bus.inst_addr_o} !== 57'b0) begin errors++; $display("FAIL reset_inst got=%0h/%0h exp=0/0", bus.inst_o, bus.inst_addr_o); end
    step();
    step();
    rst_n = 1'b1;
    idle();
    step();
  endtask

  task automatic test_basic;
    for (int k = 0; k < 5; k++) begin
      bus.pc_valid_i   = (k < 3);
      bus.pc_i         = 25'(k);
      bus.mem_rvalid_i = (k >= 1 && k <= 3);
      bus.mem_rdata_i  = 32'hA0 + 32'(k - 1);
      bus.inst_ready_i = 1'b1;
      #1;
      if (k < 3) begin
        checks++; if ({bus.pc_ready_o, bus.mem_addr_o} !== {1'b1, 25'(k)}) begin errors++; $display("FAIL basic_req k=%0d got=%0b/%0h exp=1/%0h", k, bus.pc_ready_o, bus.mem_addr_o, k); end
      end
      if (k >= 2) begin
        checks++; if ({bus.inst_valid_o, bus.inst_o, bus.inst_addr_o} !== {1'b1, 32'hA0 + 32'(k - 2), 25'(k - 2)}) begin errors++; $display("FAIL basic_inst k=%0d got=%0b/%0h/%0h exp=1/%0h/%0h", k, bus.inst_valid_o, bus.inst_o, bus.inst_addr_o, 32'hA0 + 32'(k - 2), k - 2); end
      end else begin
        checks++; if (bus.inst_valid_o !== 1'b0) begin errors++; $display("FAIL basic_early k=%0d got=%0b exp=0", k, bus.inst_valid_o); end
      end
      step();
    end
    idle();
    #1;
    checks++; if ({bus.inst_valid_o, count_o} !== 5'b0) begin errors++; $display("FAIL basic_empty got=%0b/%0d exp=0/0", bus.inst_valid_o, count_o); end
  endtask

  task automatic test_full;
    int accepted = 0;
    for (int k = 0; k < 6; k++) begin
      bus.pc_valid_i   = 1'b1;
      bus.pc_i         = 25'h10 + 25'((k < 4) ? k : 4);
      bus.mem_rvalid_i = (k >= 1 && k <= 4);
      bus.mem_rdata_i  = 32'hD0 + 32'(k - 1);
      bus.inst_ready_i = 1'b0;
      #1;
      checks++; if (bus.pc_ready_o !== (k < 4)) begin errors++; $display("FAIL full_ready k=%0d got=%0b exp=%0b", k, bus.pc_ready_o, (k < 4)); end
      if (bus.pc_ready_o) accepted++;
      step();
    end
    checks++; if (accepted !== 4) begin errors++; $display("FAIL full_accepted got=%0d exp=4", accepted); end
    bus.mem_rvalid_i = 1'b0;
    bus.inst_ready_i = 1'b1;
    #1;
    checks++; if ({count_o, bus.inst_valid_o, bus.inst_o, bus.inst_addr_o} !== {4'd4, 1'b1, 32'hD0, 25'h10}) begin errors++; $display("FAIL full_head got=%0d/%0b/%0h/%0h exp=4/1/d0/10", count_o, bus.inst_valid_o, bus.inst_o, bus.inst_addr_o); end
    checks++; if (bus.pc_ready_o !== 1'b0) begin errors++; $display("FAIL full_blocked got=%0b exp=0", bus.pc_ready_o); end
    step();
    bus.inst_ready_i = 1'b0;
    #1;
    checks++; if ({count_o, bus.pc_ready_o} !== {4'd3, 1'b1}) begin errors++; $display("FAIL full_one_more got=%0d/%0b exp=3/1", count_o, bus.pc_ready_o); end
    step();
    bus.pc_valid_i   = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hD4;
    step();
    bus.mem_rvalid_i = 1'b0;
    #1;
    checks++; if (count_o !== 4'd4) begin errors++; $display("FAIL full_refill got=%0d exp=4", count_o); end
    for (int i = 0; i < 4; i++) begin
      bus.inst_ready_i = 1'b1;
      #1;
      checks++; if ({bus.inst_o, bus.inst_addr_o} !== {32'hD1 + 32'(i), 25'h11 + 25'(i)}) begin errors++; $display("FAIL full_order i=%0d got=%0h/%0h exp=%0h/%0h", i, bus.inst_o, bus.inst_addr_o, 32'hD1 + 32'(i), 25'h11 + 25'(i)); end
      step();
    end
    idle();
    #1;
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL full_drained got=%0d exp=0", count_o); end
  endtask

  task automatic test_flush;
    for (int k = 0; k < 3; k++) begin
      bus.pc_valid_i = 1'b1;
      bus.pc_i       = 25'h20 + 25'(k);
      step();
    end
    bus.pc_valid_i = 1'b0;
    bus.flush_i    = 1'b1;
    #1;
    checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL flush_req got=%0b exp=0", bus.mem_req_o); end
    step();
    bus.flush_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.pc_valid_i   = 1'b1;
      bus.pc_i         = 25'h100;
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = 32'hDEAD0000 + 32'(k);
      #1;
      checks++; if ({bus.mem_req_o, bus.inst_valid_o, count_o} !== 6'b0) begin errors++; $display("FAIL flush_drain k=%0d got=%0b/%0b/%0d exp=0/0/0", k, bus.mem_req_o, bus.inst_valid_o, count_o); end
      step();
    end
    bus.mem_rvalid_i = 1'b0;
    #1;
    checks++; if ({bus.mem_req_o, bus.pc_ready_o, bus.mem_addr_o, bus.inst_valid_o} !== {2'b11, 25'h100, 1'b0}) begin errors++; $display("FAIL flush_resume got=%0b/%0b/%0h/%0b exp=1/1/100/0", bus.mem_req_o, bus.pc_ready_o, bus.mem_addr_o, bus.inst_valid_o); end
    step();
    bus.pc_valid_i   = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hBEEF;
    step();
    bus.mem_rvalid_i = 1'b0;
    bus.inst_ready_i = 1'b1;
    #1;
    checks++; if ({bus.inst_valid_o, bus.inst_o, bus.inst_addr_o, err_o} !== {1'b1, 32'hBEEF, 25'h100, 1'b0}) begin errors++; $display("FAIL flush_new got=%0b/%0h/%0h/%0b exp=1/beef/100/0", bus.inst_valid_o, bus.inst_o, bus.inst_addr_o, err_o); end
    step();
    idle();
  endtask

  task automatic test_simultaneous;
    for (int k = 0; k < 2; k++) begin
      bus.pc_valid_i = 1'b1;
      bus.pc_i       = 25'h30 + 25'(k);
      step();
    end
    bus.pc_valid_i   = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hCAFE;
    bus.flush_i      = 1'b1;
    step();
    bus.flush_i      = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.pc_valid_i   = 1'b1;
    #1;
    checks++; if ({bus.mem_req_o, count_o} !== 5'b0) begin errors++; $display("FAIL simul_drain got=%0b/%0d exp=0/0", bus.mem_req_o, count_o); end
    step();
    bus.mem_rvalid_i = 1'b1;
    #1;
    checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL simul_last_drop got=%0b exp=0", bus.mem_req_o); end
    step();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_gnt_i    = 1'b0;
    #1;
    checks++; if ({bus.mem_req_o, count_o, err_o} !== {1'b1, 4'd0, 1'b0}) begin errors++; $display("FAIL simul_run got=%0b/%0d/%0b exp=1/0/0", bus.mem_req_o, count_o, err_o); end
    step();
    idle();
    bus.pc_valid_i = 1'b1;
    bus.pc_i       = 25'h40;
    step();
    bus.pc_i         = 25'h41;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hE0;
    step();
    bus.pc_i         = 25'h42;
    bus.mem_rdata_i  = 32'hE1;
    bus.inst_ready_i = 1'b1;
    #1;
    checks++; if ({count_o, bus.inst_o, bus.pc_ready_o} !== {4'd1, 32'hE0, 1'b1}) begin errors++; $display("FAIL simul_pre got=%0d/%0h/%0b exp=1/e0/1", count_o, bus.inst_o, bus.pc_ready_o); end
    step();
    bus.pc_valid_i  = 1'b0;
    bus.mem_rdata_i = 32'hE2;
    #1;
    checks++; if ({count_o, bus.inst_o, bus.inst_addr_o} !== {4'd1, 32'hE1, 25'h41}) begin errors++; $display("FAIL simul_same_cycle got=%0d/%0h/%0h exp=1/e1/41", count_o, bus.inst_o, bus.inst_addr_o); end
    step();
    bus.mem_rvalid_i = 1'b0;
    #1;
    checks++; if ({count_o, bus.inst_o, bus.inst_addr_o} !== {4'd1, 32'hE2, 25'h42}) begin errors++; $display("FAIL simul_last got=%0d/%0h/%0h exp=1/e2/42", count_o, bus.inst_o, bus.inst_addr_o); end
    step();
    idle();
    #1;
    checks++; if ({count_o, bus.inst_valid_o} !== 5'b0) begin errors++; $display("FAIL simul_empty got=%0d/%0b exp=0/0", count_o, bus.inst_valid_o); end
  endtask

  task automatic test_error;
    idle();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h5A5A;
    step();
    bus.mem_rvalid_i = 1'b0;
    #1;
    checks++; if ({err_o, count_o, bus.inst_valid_o} !== {1'b1, 4'd0, 1'b0}) begin errors++; $display("FAIL error_set got=%0b/%0d/%0b exp=1/0/0", err_o, count_o, bus.inst_valid_o); end
    step();
    step();
    step();
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL error_sticky got=%0b exp=1", err_o); end
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 4; k++) begin
      bus.pc_valid_i   = (k < 3);
      bus.pc_i         = 25'h50 + 25'(k);
      bus.mem_rvalid_i = (k >= 1);
      bus.mem_rdata_i  = 32'hF0 + 32'(k - 1);
      step();
    end
    idle();
    #1;
    checks++; if (count_o !== 4'd3) begin errors++; $display("FAIL rstmid_fill got=%0d exp=3", count_o); end
    bus.pc_valid_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.inst_valid_o, count_o, bus.mem_req_o, err_o} !== 7'b0) begin errors++; $display("FAIL rstmid_async got=%0b/%0d/%0b/%0b exp=0/0/0/0", bus.inst_valid_o, count_o, bus.mem_req_o, err_o); end
    step();
    rst_n = 1'b1;
    idle();
    bus.mem_rvalid_i = 1'b1;
    step();
    bus.mem_rvalid_i = 1'b0;
    #1;
    checks++; if ({err_o, count_o} !== {1'b1, 4'd0}) begin errors++; $display("FAIL rstmid_stray got=%0b/%0d exp=1/0", err_o, count_o); end
  endtask

  initial begin
    idle();
    test_reset();
    test_basic();
    test_full();
    test_flush();
    test_simultaneous();
    test_error();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
